// File: rtl/mem_responder_if.sv
// Memory handshake bus between the control unit (master) and the memory responder (slave).
// Signals:
//   MIO_EN    request strobe (master -> slave)
//   R_W       0 = read, 1 = write (master -> slave)
//   ADDR      16-bit word address from MAR (master -> slave)
//   Data_in   16-bit write data from MDR (master -> slave)
//   Data_out  16-bit registered read data (slave -> master)
//   Mem_Ready one-cycle completion pulse (slave -> master)
//   Busy      transaction in flight (slave -> master)
//   Fault     out-of-range access flag, READY cycle only (slave -> master)
interface mem_responder_if;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] ADDR;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        Mem_Ready;
  logic        Busy;
  logic        Fault;

  modport master (
    output MIO_EN, R_W, ADDR, Data_in,
    input  Data_out, Mem_Ready, Busy, Fault
  );

  modport slave (
    input  MIO_EN, R_W, ADDR, Data_in,
    output Data_out, Mem_Ready, Busy, Fault
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the MIO_EN/R_W handshake: accepts a request in IDLE,
// waits WAIT_CYCLES cycles, then completes the access against an internal
// word-addressed RAM of 2**ADDR_W x 16 bits.
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    mem_responder_if.slave (request in, Data_out/Mem_Ready/Busy/Fault out)
// Optional feature: define MEM_FAULT_EN to flag accesses with ADDR[15:ADDR_W] != 0
// (write dropped, read returns 0, Fault for the READY cycle). Without it the
// address wraps modulo the RAM depth and Fault stays 0.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 10
) (
  input logic            Clk,
  input logic            Reset,
  mem_responder_if.slave bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                oor_q;

  logic [DATA_W-1:0]   data_out_q;
  logic                ready_q;
  logic                busy_q;
  logic                fault_q;

  logic [DATA_W-1:0]   ram [DEPTH];

  logic                oor_in_c;
  logic                latch_c;
  logic                access_c;
  logic [ADDR_W-1:0]   acc_addr_c;
  logic                acc_wr_c;
  logic [DATA_W-1:0]   acc_data_c;
  logic                acc_oor_c;

  // Out-of-range detection on the live request address
`ifdef MEM_FAULT_EN
  assign oor_in_c = |bus.ADDR[15:ADDR_W];
`else
  logic unused_upper_addr_c;
  assign unused_upper_addr_c = |bus.ADDR[15:ADDR_W];
  assign oor_in_c = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, wait counter and access strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_c    = 1'b0;
    access_c   = 1'b0;
    acc_addr_c = addr_q;
    acc_wr_c   = wr_q;
    acc_data_c = wdata_q;
    acc_oor_c  = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.MIO_EN) begin
          latch_c = 1'b1;
          if (WAIT_CYCLES == 1) begin
            // Single-cycle latency: access uses the request fields directly
            access_c   = 1'b1;
            acc_addr_c = bus.ADDR[ADDR_W-1:0];
            acc_wr_c   = bus.R_W;
            acc_data_c = bus.Data_in;
            acc_oor_c  = oor_in_c;
            state_d    = ST_READY;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          access_c = 1'b1;
          cnt_d    = '0;
          state_d  = ST_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (latch_c) begin
        addr_q  <= bus.ADDR[ADDR_W-1:0];
        wr_q    <= bus.R_W;
        wdata_q <= bus.Data_in;
        oor_q   <= oor_in_c;
      end
      if (access_c && !acc_wr_c) begin
        data_out_q <= acc_oor_c ? DATA_W'(0) : ram[acc_addr_c];
      end
      ready_q <= access_c;
      fault_q <= access_c && acc_oor_c;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // RAM write port; contents survive reset, and no write lands while Reset is low
  always_ff @(posedge Clk) begin
    if (Reset && access_c && acc_wr_c && !acc_oor_c) begin
      ram[acc_addr_c] <= acc_data_c;
    end
  end

  assign bus.Data_out  = data_out_q;
  assign bus.Mem_Ready = ready_q;
  assign bus.Busy      = busy_q;
  assign bus.Fault     = fault_q;

endmodule
